// File: rtl/pipe_stage_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf_if
// Brief    : Valid/ready handshake bundle for pipe_stage_buf (plus flush/status).
// Revision : 1.0
// ============================================================================
interface pipe_stage_buf_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;
    logic             drop;

    // master drives the stage (upstream + downstream side), slave is the stage
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, drop
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, drop
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Brief    : Valid/ready pipeline stage with flush and optional 2-entry skid.
// Revision : 1.0
// ============================================================================
module pipe_stage_buf #(
    parameter int WIDTH          = 32,
    parameter bit SKID           = 1'b1,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pipe_stage_buf_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             drop_q, drop_d;
    logic             w_accept;
    logic             w_pop;
    logic             w_in_ready;

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_pop    = (state_q != ST_EMPTY) & bus.out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        // Entries lost = held entries not popped this cycle, plus any accept.
        drop_d  = bus.flush & ((state_q == ST_FULL) |
                               ((state_q == ST_ONE) & ~w_pop) |
                               w_accept);
        if (bus.flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                m_d = '0;
                s_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d = ST_ONE;
                        m_d     = bus.in_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        m_d = bus.in_data;
                    end else if (w_accept) begin
                        state_d = ST_FULL;
                        s_d     = bus.in_data;
                    end else if (w_pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        state_d = ST_ONE;
                        m_d     = s_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            drop_q  <= drop_d;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic rdy_q;
            // Registered ready breaks the out_ready -> in_ready stall path.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    s_q   <= '0;
                    rdy_q <= 1'b0;
                end else begin
                    s_q   <= s_d;
                    rdy_q <= (state_d != ST_FULL);
                end
            end
            assign w_in_ready = rdy_q;
        end else begin : g_noskid
            assign s_q        = '0;
            assign w_in_ready = rst & ((state_q == ST_EMPTY) | bus.out_ready);
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_data  = m_q;
    assign bus.count     = state_q;
    assign bus.drop      = drop_q;

endmodule
`default_nettype wire
